display_scan_mux: RTL

//  Time-multiplexed scanner feeding the hex-to-7-segment decoder. Holds an
//  N-digit hex value, and presents one 4-bit digit per scan slot on hexa,

---
 rtl/display_scan_pkg.sv | 27 ++
 rtl/display_scan_mux_tick.sv | 39 +++
 rtl/display_scan_mux.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/display_scan_pkg.sv
// ----------------------------------------------------------------------------
// display_scan_pkg
//   Shared types and helpers for the display scan multiplexer.
//   - scan_state_t : scanner FSM state (IDLE, SCAN)
//   - DIGIT_W      : bits per hex digit
//   - MAX_DIGITS   : largest supported digit count; width of onehot_sel()
//   - IDX_W        : digit index width for the default 4-digit build
//   - onehot_sel() : one-hot digit select from a digit index
// ----------------------------------------------------------------------------
package display_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam int DIGIT_W      = 4;
    localparam int MAX_DIGITS   = 8;
    localparam int N_DIGITS_DEF = 4;
    localparam int IDX_W        = $clog2(N_DIGITS_DEF);

    // The caller slices the low N_DIGITS bits.
    function automatic logic [MAX_DIGITS-1:0] onehot_sel(input int idx);
        onehot_sel = MAX_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/display_scan_mux_tick.sv
// ----------------------------------------------------------------------------
// scan_tick_gen
//   Digit-slot prescaler. It counts 0..TICK_DIV-1 and wraps. slot_end is high
//   for the single cycle in which the count sits at TICK_DIV-1.
//   clear holds the count at 0 and suppresses slot_end.
// Ports
//   clock     in  system clock, rising edge
//   reset     in  synchronous, active-low
//   clear     in  1 = hold prescaler at 0
//   slot_end  out 1-cycle pulse on the last cycle of a slot
// ----------------------------------------------------------------------------
module scan_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic slot_end
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] count;
    logic          at_end;

    assign at_end   = (count == CW'(TICK_DIV - 1));
    assign slot_end = at_end && !clear;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (at_end) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// ----------------------------------------------------------------------------
// display_scan_mux
//   Time-multiplexed scanner for an N-digit hex value. Each scan slot presents
//   one digit on hexa, a one-hot select on digito_sel and a blank flag.
//   A new value is captured into a pending register on load. It becomes
//   visible only at a frame boundary, so a frame never shows a mix of old and
//   new digits.
//   Optional macro DISPLAY_SCAN_LZB_EN enables leading-zero blanking.
// Ports
//   clock        in  system clock, rising edge
//   reset        in  synchronous, active-low
//   enable       in  1 = scan, 0 = idle/dark
//   load         in  1-cycle strobe, captures valor into the pending register
//   valor        in  hex value, digit k = valor[4k+3:4k]
//   blank_mask   in  1 = force digit k blank (sampled live)
//   hexa         out current digit code
//   digito_sel   out one-hot digit select, 0 when idle
//   blank        out 1 = current digit dark
//   frame_start  out 1-cycle pulse when the digit 0 slot begins
// ----------------------------------------------------------------------------
//   state | meaning
//   IDLE  | display dark, prescaler and index held at 0
//   SCAN  | cycling digit slots, TICK_DIV cycles each
// ----------------------------------------------------------------------------
module display_scan_mux
    import display_scan_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int TICK_DIV = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] valor,
    input  logic [N_DIGITS-1:0]   blank_mask,
    output logic [3:0]            hexa,
    output logic [N_DIGITS-1:0]   digito_sel,
    output logic                  blank,
    output logic                  frame_start
);

    localparam int IW = $clog2(N_DIGITS);

    scan_state_t           state;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_nxt;
    logic [4*N_DIGITS-1:0] pending;
    logic [4*N_DIGITS-1:0] active;
    logic [4*N_DIGITS-1:0] active_nxt;
    logic [4*N_DIGITS-1:0] commit_val;
    logic                  slot_end;
    logic                  tick_clear;
    logic                  last_slot;
    logic                  commit;
    logic [N_DIGITS-1:0]   lz_blank;
    logic [MAX_DIGITS-1:0] sel_full;

    // The prescaler is released only while scanning continues. The entry edge
    // therefore starts digit 0 with a count of 0, which gives a full slot.
    assign tick_clear = (state == IDLE) || !enable;

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock    (clock),
        .reset    (reset),
        .clear    (tick_clear),
        .slot_end (slot_end)
    );

    assign last_slot  = (idx == IW'(N_DIGITS - 1));
    // A load on the same edge as a commit bypasses pending.
    assign commit_val = load ? valor : pending;
    assign commit     = enable && ((state == IDLE) || (slot_end && last_slot));
    assign active_nxt = commit ? commit_val : active;

    always_comb begin
        idx_nxt = idx;
        if ((state == IDLE) || !enable) begin
            idx_nxt = '0;
        end else if (slot_end) begin
            idx_nxt = last_slot ? '0 : idx + IW'(1);
        end
    end

    assign sel_full = onehot_sel(int'(idx_nxt));

    // Leading-zero blanking: a digit is dark when it and every digit above it
    // are zero. Digit 0 is always shown.
`ifdef DISPLAY_SCAN_LZB_EN
    logic upper_zero;
    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            upper_zero  = upper_zero && (active_nxt[4*k +: 4] == 4'h0);
            lz_blank[k] = upper_zero;
        end
    end
`else
    always_comb begin
        lz_blank = '0;
    end
`endif

    // Outputs are computed from the next index and the next active value.
    // They therefore change on the same edge as idx and state. Because blank
    // is recomputed every cycle, blank_mask changes take effect mid-slot.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            pending     <= '0;
            active      <= '0;
            hexa        <= 4'h0;
            digito_sel  <= '0;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (load) begin
                pending <= valor;
            end
            active <= active_nxt;
            idx    <= idx_nxt;

            case (state)
                IDLE:    state <= enable ? SCAN : IDLE;
                SCAN:    state <= enable ? SCAN : IDLE;
                default: state <= IDLE;
            endcase

            if (enable) begin
                hexa        <= active_nxt[{idx_nxt, 2'b00} +: 4];
                digito_sel  <= sel_full[N_DIGITS-1:0];
                blank       <= blank_mask[idx_nxt] | lz_blank[idx_nxt];
                frame_start <= commit;
            end else begin
                hexa        <= 4'h0;
                digito_sel  <= '0;
                blank       <= 1'b1;
                frame_start <= 1'b0;
            end
        end
    end

endmodule
